// File: rtl/fp_pkg.sv
// Shared widths, defaults and FSM state type for the FP operand aligner.
package fp_pkg;

  localparam int EXP_W         = 8;
  localparam int FRAC_W        = 24;
  localparam int GRS_W         = 3;
  localparam int ALIGN_W       = 27;
  localparam int MAX_SHIFT_DEF = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shr_sticky.sv
// One alignment step: right-shift the GRS-extended fraction by 0..STEP bits.
// With ALIGN_STICKY_EN defined, bits leaving or landing at bit 0 are OR-ed into sticky.
module shr_sticky
  import fp_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [ALIGN_W-1:0] r_in,
  input  logic [3:0]         amt,
  output logic [ALIGN_W-1:0] r_out
);

`ifdef ALIGN_STICKY_EN
  logic [ALIGN_W-1:0] shifted;
  logic               sticky;

  always_comb begin
    shifted = r_in >> amt;
    sticky  = r_in[0];
    for (int i = 1; i <= STEP; i++) begin
      if (4'(i) <= amt) sticky = sticky | r_in[i];
    end
    r_out = {shifted[ALIGN_W-1:1], sticky};
  end
`else
  // Truncation: anything reaching bit 0 is dropped.
  always_comb begin
    r_out = (r_in >> amt) & ~ALIGN_W'(1);
  end
`endif

endmodule

// File: rtl/fp_align_shift.sv
// Iterative right-shift aligner for the FP adder path, STEP bits per cycle.
// Optional sticky accumulation is enabled by defining ALIGN_STICKY_EN.
module fp_align_shift
  import fp_pkg::*;
#(
  parameter int STEP      = 1,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXP_W-1:0]    exp_in,
  input  logic [EXP_W-1:0]    exp_target,
  input  logic [FRAC_W-1:0]   frac_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXP_W-1:0]    exp_out,
  output logic [ALIGN_W-1:0]  frac_out,
  output logic                err
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready is high only in IDLE and out_valid only in DONE, so an output
  // handshake and a new accept can never share a cycle.

  state_t             state_q, state_d;
  logic [ALIGN_W-1:0] r_q, r_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               err_q, err_d;

  logic [8:0]         diff;
  logic [3:0]         k;
  logic [ALIGN_W-1:0] r_shr;

  // 9-bit difference: bit 8 set means exp_in is above the target.
  assign diff = {1'b0, exp_target} - {1'b0, exp_in};
  assign k    = (cnt_q < 9'(STEP)) ? cnt_q[3:0] : 4'(STEP);

  shr_sticky #(
    .STEP (STEP)
  ) u_shr (
    .r_in  (r_q),
    .amt   (k),
    .r_out (r_shr)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d   = {frac_in, 3'b000};
          err_d = 1'b0;
          exp_d = exp_target;
          if (diff[8]) begin
            err_d   = 1'b1;
            exp_d   = exp_in;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = (diff >= 9'(MAX_SHIFT)) ? 9'(MAX_SHIFT) : diff;
            state_d = (diff == 9'd0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        r_d   = r_shr;
        cnt_d = cnt_q - {5'b0, k};
        if (cnt_q == {5'b0, k}) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign frac_out  = out_valid ? r_q : '0;
  assign exp_out   = exp_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fp_align_shift.sv
// Directed bench for fp_align_shift: a STEP=1 and a STEP=4 instance share operand inputs.
module tb_fp_align_shift;

`ifdef ALIGN_STICKY_EN
  localparam logic S = 1'b1;
`else
  localparam logic S = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  exp_in = '0;
  logic [7:0]  exp_target = '0;
  logic [23:0] frac_in = '0;
  logic        in_valid1 = 1'b0, in_valid4 = 1'b0;
  logic        out_ready1 = 1'b0, out_ready4 = 1'b0;
  logic        in_ready1, in_ready4, out_valid1, out_valid4, err1, err4;
  logic [7:0]  exp_out1, exp_out4;
  logic [26:0] frac_out1, frac_out4;
  logic        sel4 = 1'b0;

  logic        o_in_ready, o_out_valid, o_err;
  logic [7:0]  o_exp;
  logic [26:0] o_frac;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_align_shift #(.STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .exp_in(exp_in), .exp_target(exp_target), .frac_in(frac_in),
    .out_valid(out_valid1), .out_ready(out_ready1), .exp_out(exp_out1),
    .frac_out(frac_out1), .err(err1)
  );

  fp_align_shift #(.STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .exp_in(exp_in), .exp_target(exp_target), .frac_in(frac_in),
    .out_valid(out_valid4), .out_ready(out_ready4), .exp_out(exp_out4),
    .frac_out(frac_out4), .err(err4)
  );

  assign o_in_ready  = sel4 ? in_ready4  : in_ready1;
  assign o_out_valid = sel4 ? out_valid4 : out_valid1;
  assign o_err       = sel4 ? err4       : err1;
  assign o_exp       = sel4 ? exp_out4   : exp_out1;
  assign o_frac      = sel4 ? frac_out4  : frac_out1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic use4, input logic [7:0] ei, input logic [7:0] et,
                        input logic [23:0] fi, input logic [26:0] e_frac,
                        input logic [7:0] e_exp, input logic e_err, input int e_lat,
                        input string tag);
    int lat;
    sel4 = use4;
    check({tag, "_in_ready"}, {31'b0, o_in_ready}, 32'd1);
    exp_in = ei; exp_target = et; frac_in = fi;
    if (use4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    lat = 1;
    while (!o_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},  lat,            e_lat);
    check({tag, "_frac"}, {5'b0, o_frac}, {5'b0, e_frac});
    check({tag, "_exp"},  {24'b0, o_exp}, {24'b0, e_exp});
    check({tag, "_err"},  {31'b0, o_err}, {31'b0, e_err});
  endtask

  task automatic consume(input string tag);
    if (sel4) out_ready4 = 1'b1; else out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0; out_ready4 = 1'b0;
    check({tag, "_drop_valid"}, {31'b0, o_out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'b0, o_in_ready},  32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sel4 = 1'b0;
    check("rst_in_ready",  {31'b0, o_in_ready},  32'd1);
    check("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
    check("rst_err",       {31'b0, o_err},       32'd0);
    check("rst_exp",       {24'b0, o_exp},       32'd0);
    check("rst_frac",      {5'b0, o_frac},       32'd0);

    // d=2 then hold in DONE with out_ready low
    run_op(1'b0, 8'd125, 8'd127, 24'h800000, 27'h1000000, 8'd127, 1'b0, 3, "d2");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_frac",     {5'b0, o_frac},       32'h1000000);
      check("hold_exp",      {24'b0, o_exp},       32'd127);
      check("hold_in_ready", {31'b0, o_in_ready},  32'd0);
      check("hold_valid",    {31'b0, o_out_valid}, 32'd1);
    end
    consume("d2");

    run_op(1'b0, 8'd123, 8'd127, 24'hC00001, 27'h600000 | 27'(S), 8'd127, 1'b0, 5, "d4_sticky");
    consume("d4_sticky");

    run_op(1'b0, 8'd0, 8'd200, 24'hFFFFFF, 27'(S), 8'd200, 1'b0, 28, "clamp1");
    consume("clamp1");

    run_op(1'b0, 8'd130, 8'd127, 24'hABCDEF, 27'h55E6F78, 8'd130, 1'b1, 1, "err");
    consume("err");

    // err must clear on the next accept
    run_op(1'b0, 8'd0, 8'd0, 24'h7FFFFF, 27'h3FFFFF8, 8'd0, 1'b0, 1, "denorm");
    consume("denorm");

    run_op(1'b0, 8'd10, 8'd15, 24'h000000, 27'h0, 8'd15, 1'b0, 6, "zero_frac");
    consume("zero_frac");

    run_op(1'b1, 8'd0, 8'd200, 24'hFFFFFF, 27'(S), 8'd200, 1'b0, 8, "clamp4");
    consume("clamp4");

    run_op(1'b1, 8'd20, 8'd25, 24'h00001F, 27'h6 | 27'(S), 8'd25, 1'b0, 3, "step4_d5");
    consume("step4_d5");

    // reset during the second SHIFT cycle of a d=10 operation
    sel4 = 1'b0;
    exp_in = 8'd100; exp_target = 8'd110; frac_in = 24'h9ABCDE;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", {31'b0, o_out_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, o_in_ready},  32'd1);
    check("mid_rst_frac",  {5'b0, o_frac},       32'd0);

    run_op(1'b0, 8'd50, 8'd50, 24'h123456, 27'h91A2B0, 8'd50, 1'b0, 1, "post_rst_d0");
    consume("post_rst_d0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_align_shift.md
Name: fp_align_shift

Overview:
- Right-shift operand aligner for the FP adder path; the inverse of the post-multiply normaliser.
- Normalisation shifts the fraction left and lowers the exponent. This block shifts the smaller operand's fraction right until its exponent equals the target (larger) exponent.
- Iterative: STEP bits per cycle, valid/ready on both sides.
- Produces a 27-bit aligned fraction {24-bit frac, guard, round, sticky} for the adder and rounder.

Parameters:
- STEP, 1, bits shifted per cycle; legal values 1, 2, 4, 8.
- MAX_SHIFT, 27, shift clamp; any larger distance flushes every data bit into sticky.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- exp_in  in  8  biased exponent of the operand to align.
- exp_target  in  8  biased exponent to align to.
- frac_in  in  24  fraction with hidden bit at [23].
- out_valid  out  1  aligned result valid.
- out_ready  in  1  consumer accepts the result.
- exp_out  out  8  result exponent.
- frac_out  out  27  aligned {frac[23:0], G, R, S}.
- err  out  1  exp_in > exp_target; operand passed unshifted.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, err=0, exp_out=0, frac_out=0.
- Reset mid-operation abandons the transaction; IDLE on the next cycle.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load r[26:0]={frac_in,3'b000}.
  - Shift distance d=exp_target-exp_in, computed in 9 bits.
  - cnt=min(d,MAX_SHIFT).
  - exp_out=exp_target.
  - If cnt==0, go to DONE; else go to SHIFT.
- Input with exp_in>exp_target (9-bit difference negative):
  - err=1, exp_out=exp_in, r={frac_in,3'b000}.
  - Go to DONE directly.
- State SHIFT:
  - Each cycle k=min(STEP,cnt).
  - r[26:1] shifts right by k; zeros fill from the top.
  - r[0] = r[0] OR (every bit shifted out of or landing at position 0).
  - cnt-=k.
  - When cnt reaches 0, go to DONE.
- State DONE:
  - out_valid=1; frac_out=r; exp_out and err stay stable.
  - On out_ready, go to IDLE; out_valid drops next cycle.
  - Outputs hold while out_ready=0.
- in_ready=0 in SHIFT and DONE; no new accept in the same cycle as the output handshake.
- Latency, accept edge to out_valid: ceil(cnt/STEP)+1 cycles. d=0 gives 1 cycle.
- Boundaries:
  - d>=27 clamps to 27: all data bits go out; frac_out=27'd1 if frac_in!=0, else 0.
  - frac_in==0: shifts normally; result 0, sticky 0.
  - exp_in==exp_target==0 (denormal): d=0, pass-through.
- err clears on the next accept.

Optional Feature:
- Macro: ALIGN_STICKY_EN.
- Defined: sticky accumulation as above.
- Undefined: bits below position 1 are discarded and frac_out[0] is forced to 0 (truncation). Shift distances and latency are unchanged.

Decomposition:
- Package fp_pkg:
  - EXP_W=8, FRAC_W=24, GRS_W=3, ALIGN_W=27, MAX_SHIFT_DEF=27.
  - State enum {IDLE, SHIFT, DONE}.
- Sub-module shr_sticky: combinational; input 27-bit r and shift amount 0..STEP; output is the shifted word with the merged sticky bit. The sticky merge is gated by ALIGN_STICKY_EN. One instance.

Test Plan:
- STEP=1; frac_in=24'h800000, exp_in=125, exp_target=127 -> exp_out=127, frac_out=27'h1000000 (frac 24'h200000, GRS 000), out_valid 3 cycles after accept.
- STEP=1; frac_in=24'hC00001, exp_in=123, exp_target=127 -> frac_out={24'h0C0000,3'b001}. Without ALIGN_STICKY_EN -> {24'h0C0000,3'b000}.
- STEP=1; frac_in=24'hFFFFFF, exp_in=0, exp_target=200 -> clamp to 27, frac_out=27'd1, out_valid 28 cycles after accept. STEP=4 -> same result after 8 cycles.
- frac_in=24'hABCDEF, exp_in=130, exp_target=127 -> err=1, exp_out=130, frac_out={24'hABCDEF,3'b000}, out_valid 1 cycle after accept.
- DONE with out_ready held 0 for 5 cycles -> frac_out and exp_out stable, in_ready=0. out_ready=1 -> IDLE and in_ready=1 next cycle.
- rst asserted in the 2nd SHIFT cycle of a d=10 operation -> next cycle out_valid=0, in_ready=1, frac_out=0. A new d=0 operand then completes in 1 cycle.
